// File: rtl/ams_pkg.sv
// Shared constants, DAC word type and duty saturation helper for the AMS PWM DAC channels.
// The pattern-dither option of ams_pwm_dac is enabled by defining AMS_PWM_DITHER_EN.
package ams_pkg;

    localparam int AMS_PWM_FULL = 156;

    localparam int BASE_MSB = 23;
    localparam int BASE_LSB = 16;
    localparam int PAT_W    = 16;
    localparam int DAC_W    = 24;

    typedef logic [DAC_W-1:0] dac_word_t;

    // Clamp a 9-bit duty sum to the period length so oversized bases read as always-on.
    function automatic logic [8:0] ams_sat(input logic [8:0] x, input logic [8:0] lim);
        return (x > lim) ? lim : x;
    endfunction

endpackage

// File: rtl/ams_pwm_cnt.sv
// Period (vcnt) and frame (bcnt) counter for one PWM channel.
// Strobes are combinational and mark the last cycle of a period / of a 16-period frame.
module ams_pwm_cnt #(
    parameter int FULL  = 156,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [CNT_W-1:0] vcnt,
    output logic [3:0]       bcnt,
    output logic             period_end,
    output logic             frame_end
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FULL - 1);

    logic [CNT_W-1:0] vcnt_reg;
    logic [3:0]       bcnt_reg;

    assign vcnt       = vcnt_reg;
    assign bcnt       = bcnt_reg;
    assign period_end = (vcnt_reg == LAST);
    assign frame_end  = period_end && (bcnt_reg == 4'hF);

    // Reset parks both counters on their last value so the first live edge is a frame boundary.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vcnt_reg <= LAST;
            bcnt_reg <= 4'hF;
        end else if (period_end) begin
            vcnt_reg <= '0;
            bcnt_reg <= bcnt_reg + 4'd1;
        end else begin
            vcnt_reg <= vcnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ams_pwm_dac.sv
// Single-channel PWM DAC modulator: 8-bit base duty plus optional 16-period dither.
// Define AMS_PWM_DITHER_EN to enable the per-period dither pattern in cfg_i[15:0].
module ams_pwm_dac
    import ams_pkg::*;
#(
    parameter int FULL  = AMS_PWM_FULL,
    parameter int CNT_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [23:0] cfg_i,
    output logic        pwm_o,
    output logic        frame_o
);

    localparam logic [8:0] FULL_V = 9'(FULL);

    logic [CNT_W-1:0] vcnt;
    logic [3:0]       bcnt;
    logic             period_end;
    logic             frame_end;

    ams_pwm_cnt #(
        .FULL  (FULL),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .vcnt       (vcnt),
        .bcnt       (bcnt),
        .period_end (period_end),
        .frame_end  (frame_end)
    );

    dac_word_t  cfg_word;
    logic [7:0] cfg_base;
    logic [7:0] base_reg, base_next;
    logic [8:0] v_reg, v_next;
    logic       pwm_reg, pwm_next;
    logic       frame_reg;
    logic       period_bit;
    logic       frame_bit;

    assign cfg_word = cfg_i;
    assign cfg_base = cfg_word[BASE_MSB:BASE_LSB];

`ifdef AMS_PWM_DITHER_EN
    logic [PAT_W-1:0] pat_reg, pat_next;
    logic [3:0]       bcnt_nxt;

    // The upcoming period's dither bit is indexed by the incremented frame counter.
    assign bcnt_nxt   = bcnt + 4'd1;
    assign period_bit = pat_reg[bcnt_nxt];
    assign frame_bit  = cfg_word[0];
    assign pat_next   = frame_end ? cfg_word[PAT_W-1:0] : pat_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pat_reg <= '0;
        end else begin
            pat_reg <= pat_next;
        end
    end
`else
    logic unused_pat;

    assign period_bit = 1'b0;
    assign frame_bit  = 1'b0;
    assign unused_pat = ^cfg_word[PAT_W-1:0];
`endif

    always_comb begin
        base_next = base_reg;
        v_next    = v_reg;
        // Base and pattern are captured together only at the frame boundary to avoid tearing.
        if (frame_end) begin
            base_next = cfg_base;
            v_next    = ams_sat({1'b0, cfg_base} + {8'd0, frame_bit}, FULL_V);
        end else if (period_end) begin
            v_next    = ams_sat({1'b0, base_reg} + {8'd0, period_bit}, FULL_V);
        end
        pwm_next = (9'(vcnt) < v_reg);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_reg  <= '0;
            v_reg     <= '0;
            pwm_reg   <= 1'b0;
            frame_reg <= 1'b0;
        end else begin
            base_reg  <= base_next;
            v_reg     <= v_next;
            pwm_reg   <= pwm_next;
            frame_reg <= frame_end;
        end
    end

    assign pwm_o   = pwm_reg;
    assign frame_o = frame_reg;

endmodule

// File: tb/tb_ams_pwm_dac.sv
// Directed self-checking bench for ams_pwm_dac; expected duties are hand-derived per cfg word.
// Expectations follow AMS_PWM_DITHER_EN when that macro is defined for the build.
module tb_ams_pwm_dac;

    localparam int FULL = 156;

`ifdef AMS_PWM_DITHER_EN
    localparam bit DITH = 1'b1;
`else
    localparam bit DITH = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [23:0] cfg_i = 24'h000000;
    logic        pwm_o;
    logic        frame_o;

    int n_checks = 0;
    int n_fail   = 0;

    ams_pwm_dac #(
        .FULL  (FULL),
        .CNT_W (8)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .cfg_i   (cfg_i),
        .pwm_o   (pwm_o),
        .frame_o (frame_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Starts on the sample where frame_o is high and ends on the next one. Period 0 expects e0
    // high cycles, other even periods ee, odd periods eo. cfg_i switches to chg_cfg at chg_at.
    task automatic check_frame(input string tag, input int e0, input int ee, input int eo,
                               input int chg_at, input logic [23:0] chg_cfg);
        int mism;
        int fstray;
        int exp_k;
        fstray = 0;
        for (int k = 0; k < 16; k++) begin
            exp_k = (k == 0) ? e0 : (((k % 2) == 0) ? ee : eo);
            mism  = 0;
            for (int j = 0; j < FULL; j++) begin
                if (k * FULL + j == chg_at) cfg_i = chg_cfg;
                step();
                if (pwm_o !== ((j < exp_k) ? 1'b1 : 1'b0)) mism++;
                if (!(k == 15 && j == FULL - 1) && frame_o !== 1'b0) fstray++;
            end
            check($sformatf("%s_period%0d_shape", tag, k), mism, 0);
        end
        check({tag, "_frame_stray"}, fstray, 0);
        check({tag, "_frame_pulse"}, {31'd0, frame_o}, 1);
        $display("frame %s: e0=%0d even=%0d odd=%0d checked", tag, e0, ee, eo);
    endtask

    initial begin
        // Reset state and start-up latency
        cfg_i = 24'h4E0000;
        rst_i = 1'b1;
        step();
        step();
        check("reset_pwm", {31'd0, pwm_o}, 0);
        check("reset_frame", {31'd0, frame_o}, 0);
        rst_i = 1'b0;
        step();
        check("first_edge_frame", {31'd0, frame_o}, 1);
        check("first_edge_pwm", {31'd0, pwm_o}, 0);
        $display("reset release: frame_o=%0b pwm_o=%0b", frame_o, pwm_o);

        // 78/78 duty, then a mid-frame cfg change that must wait for the next frame
        check_frame("base78_a", 78, 78, 78, -1, 24'h0);
        check_frame("base78_chg", 78, 78, 78, 500, 24'h0F0000);
        check_frame("base15", 15, 15, 15, 100, 24'h0F5555);

        // Dither pattern 0x5555: even periods get the extra cycle
        check_frame("dith5555", DITH ? 16 : 15, DITH ? 16 : 15, 15, 100, 24'h9CFFFF);

        // Saturation and constant levels
        check_frame("full9C", FULL, FULL, FULL, 100, 24'hC80000);
        check_frame("sat200", FULL, FULL, FULL, 100, 24'h000000);
        check_frame("zero", 0, 0, 0, 100, 24'h010001);

        // Single dither bit in period 0
        check_frame("dith0001", DITH ? 2 : 1, 1, 1, 100, 24'h4E0000);
        check_frame("base78_b", 78, 78, 78, -1, 24'h0);

        // Reset pulse while pwm_o is high mid-period, new cfg taken at restart
        for (int i = 0; i < 10; i++) step();
        check("pre_reset_pwm", {31'd0, pwm_o}, 1);
        cfg_i = 24'h0F0000;
        rst_i = 1'b1;
        step();
        check("midreset_pwm", {31'd0, pwm_o}, 0);
        check("midreset_frame", {31'd0, frame_o}, 0);
        rst_i = 1'b0;
        step();
        check("restart_frame", {31'd0, frame_o}, 1);
        check("restart_pwm", {31'd0, pwm_o}, 0);
        check_frame("after_reset15", 15, 15, 15, -1, 24'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ams_pwm_dac.md
Name: ams_pwm_dac

Overview:
- Single-channel PWM DAC modulator, downstream of the analog-mixed-signal register block.
- Consumes one 24-bit DAC word (dac_a..dac_d) and drives one 1-bit PWM pin toward the external RC filter; instantiated four times.
- Word format: [23:16] base duty, [15:0] per-period dither pattern. Gives 8-bit PWM with 4 extra dithered bits over a 16-period frame.

Parameters:
- FULL, 156, PWM period length in clk_i cycles; also the duty saturation ceiling; legal range 2..255.
- CNT_W, 8, width of period counter and duty registers.

Ports:
- clk_i  in  1  clock (ADC clock domain, same as the register block).
- rst_i  in  1  reset: synchronous, active-high.
- cfg_i  in  24  DAC word from the register block; [23:16] base, [15:0] dither pattern.
- pwm_o  out  1  registered PWM output.
- frame_o  out  1  one-cycle pulse marking the first cycle of each 16-period frame.

Behaviour:
- State: vcnt (CNT_W, 0..FULL-1), bcnt (4 bit, 0..15), base_r (8), b_r (16), v_r (9, current-period duty).
- Reset (rst_i=1 at edge):
  - vcnt=FULL-1, bcnt=15, base_r=0, b_r=0, v_r=0, pwm_o=0, frame_o=0.
  - The first edge after reset deasserts is therefore a frame boundary.
- Normal cycle (vcnt<FULL-1): vcnt<=vcnt+1; bcnt, v_r, base_r and b_r hold.
- Period boundary (vcnt==FULL-1, bcnt!=15): vcnt<=0; bcnt<=bcnt+1; v_r<=sat(base_r + b_r[bcnt+1]).
- Frame boundary (vcnt==FULL-1, bcnt==15):
  - vcnt<=0, bcnt<=0.
  - base_r<=cfg_i[23:16], b_r<=cfg_i[15:0].
  - v_r<=sat(cfg_i[23:16] + cfg_i[0]).
- sat(x): 9-bit sum clamped to FULL. Base values above FULL (157..255) behave as FULL, i.e. the output is constantly high.
- pwm_o <= (vcnt < v_r), so it is registered and follows vcnt by 1 cycle.
  - Each period produces exactly v_r high cycles, contiguous from period start.
  - v_r=0 gives constant low; v_r=FULL gives constant high with no glitch across boundaries.
- frame_o <= frame-boundary condition; high during the cycle where vcnt==0 and bcnt==0.
- cfg_i is sampled only at frame boundaries. Changes mid-frame are ignored until the next boundary, which prevents tearing between base and pattern. cfg_i needs no handshake because it is quasi-static register data.
- Latency from a cfg_i change to its effect on pwm_o: at most 16*FULL+1 cycles.
- Reset mid-operation: pwm_o low on the next cycle, then restart from a fresh frame with cfg_i re-sampled.

Optional Feature:
- Macro: AMS_PWM_DITHER_EN.
- Defined: dither as described above. Average duty = (16*base + popcount(pattern))/(16*FULL).
- Undefined:
  - b_r is removed and the pattern bits are ignored.
  - v_r = sat(base_r) every period; frame timing and frame_o are unchanged.

Decomposition:
- Shared package ams_pkg holds:
  - AMS_PWM_FULL (156);
  - DAC word field constants (BASE_MSB=23, BASE_LSB=16, PAT_W=16);
  - a typedef for the 24-bit DAC word;
  - the saturation function.
- One natural sub-module: ams_pwm_cnt, the vcnt/bcnt period-and-frame counter producing period_end/frame_end strobes and bcnt.

Test Plan:
- cfg=0x4E0000 after reset → every period exactly 78 high then 78 low; frame_o every 2496 cycles; first pwm_o high 2 cycles after reset release.
- cfg=0x0F5555, dither on → even periods 15+1=16 high, odd periods 15 high; 248 high cycles per frame. Dither off → 15 every period, 240 per frame.
- cfg=0x9CFFFF and cfg=0xC80000 → pwm_o constantly high across all boundaries (saturation at 156); cfg=0x000000 → constantly low.
- cfg changed from 0x4E0000 to 0x0F0000 at frame cycle 500 → remaining periods of the frame stay at 78; first period after the next frame_o is 15.
- rst_i pulsed for 1 cycle mid-period while pwm_o=1 → pwm_o=0 the cycle after; the next frame starts on the following edge with cfg re-sampled.
- cfg=0x010001, dither on → period 0 of the frame has 2 high cycles, periods 1..15 have 1 each.
